// File: rtl/mem_arbiter_if.sv
// Request/response bus between a requester (master) and a responder (slave).
// The arbiter is the slave of the IFU and LSU buses and the master of the memory bus.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    logic              resp_valid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req_valid, addr, wen, wdata, wmask,
        input  req_ready, resp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wmask,
        output req_ready, resp_valid, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store,
// one outstanding transaction, with a response timeout that returns POISON.
module mem_arbiter #(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter int                MASK_W  = 8,
    parameter int                TIMEOUT = 255,
    parameter logic [DATA_W-1:0] POISON  = 32'hdeadbeef
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  ifu,
    mem_arbiter_if.slave  lsu,
    mem_arbiter_if.master mem,
    output logic          err
);
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic              OWN_IFU  = 1'b0;
    localparam logic              OWN_LSU  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MREQ  = 2'd1,
        S_MWAIT = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q;
    logic              owner_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [DATA_W-1:0] ifu_rdata_q;
    logic [DATA_W-1:0] lsu_rdata_q;

    logic              grant_ifu_s;
    logic              grant_lsu_s;
    logic              resp_hit_s;
    logic              timeout_s;
    logic              done_s;
    logic [DATA_W-1:0] rdata_cap_s;
    logic              unused_ifu_s;

    // State register and MWAIT cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ifu_s || grant_lsu_s) state_d = S_MREQ;
                else                            state_d = S_IDLE;
            end
            S_MREQ: begin
                if (mem.req_ready) begin
                    state_d = S_MWAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = S_MREQ;
                end
            end
            S_MWAIT: begin
                if (done_s) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_MWAIT;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: grants, response capture and timeout detection
    always_comb begin
        grant_ifu_s = 1'b0;
        grant_lsu_s = 1'b0;
        resp_hit_s  = (state_q == S_MWAIT) && mem.resp_valid;
        timeout_s   = (state_q == S_MWAIT) && !mem.resp_valid && (cnt_q == CNT_LAST);
        // A response always wins over a timeout landing in the same cycle.
        if (timeout_s)  rdata_cap_s = POISON;
        else if (wen_q) rdata_cap_s = '0;
        else            rdata_cap_s = mem.rdata;
        if ((state_q == S_IDLE) && rst) begin
            if (ifu.req_valid && lsu.req_valid) begin
                if (last_grant_q == OWN_LSU) grant_ifu_s = 1'b1;
                else                         grant_lsu_s = 1'b1;
            end else begin
                grant_ifu_s = ifu.req_valid;
                grant_lsu_s = lsu.req_valid;
            end
        end else begin
            grant_ifu_s = 1'b0;
            grant_lsu_s = 1'b0;
        end
    end

    assign done_s = resp_hit_s | timeout_s;

    // Grant bookkeeping and request payload latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= OWN_LSU;
            owner_q      <= OWN_IFU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else if (grant_ifu_s) begin
            last_grant_q <= OWN_IFU;
            owner_q      <= OWN_IFU;
            addr_q       <= ifu.addr;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else if (grant_lsu_s) begin
            last_grant_q <= OWN_LSU;
            owner_q      <= OWN_LSU;
            addr_q       <= lsu.addr;
            wen_q        <= lsu.wen;
            wdata_q      <= lsu.wdata;
            wmask_q      <= lsu.wmask;
        end
    end

    // Response data registers and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (done_s) begin
                if (owner_q == OWN_LSU) lsu_rdata_q <= rdata_cap_s;
                else                    ifu_rdata_q <= rdata_cap_s;
            end
            if (timeout_s) err_q <= 1'b1;
        end
    end

    assign ifu.req_ready  = grant_ifu_s;
    assign lsu.req_ready  = grant_lsu_s;
    assign ifu.resp_valid = (state_q == S_RESP) && (owner_q == OWN_IFU);
    assign lsu.resp_valid = (state_q == S_RESP) && (owner_q == OWN_LSU);
    assign ifu.rdata      = ifu_rdata_q;
    assign lsu.rdata      = lsu_rdata_q;
    assign mem.req_valid  = (state_q == S_MREQ);
    assign mem.addr       = addr_q;
    assign mem.wen        = wen_q;
    assign mem.wdata      = wdata_q;
    assign mem.wmask      = wmask_q;
    assign err            = err_q;

    // Fetch never writes, so its write fields on the shared bus type are ignored.
    assign unused_ifu_s   = ^{ifu.wen, ifu.wdata, ifu.wmask};
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized transactions for mem_arbiter, checked against a
// transaction-level reference model (round-robin winner, expected data, sticky error).
module tb_mem_arbiter;
    localparam int          TO     = 4;
    localparam logic [31:0] POISON = 32'hdeadbeef;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MASK_W(8)) ifu_bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MASK_W(8)) lsu_bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MASK_W(8)) mem_bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(8), .TIMEOUT(TO), .POISON(POISON)) dut (
        .clk(clk), .rst(rst), .ifu(ifu_bus), .lsu(lsu_bus), .mem(mem_bus), .err(err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          last_lsu_m;
    logic [31:0] ifu_rd_m, lsu_rd_m;
    bit          err_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        last_lsu_m = 1'b1;
        ifu_rd_m   = 32'h0;
        lsu_rd_m   = 32'h0;
        err_m      = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ctrl"}, {ifu_bus.req_ready, lsu_bus.req_ready, ifu_bus.resp_valid,
                             lsu_bus.resp_valid, mem_bus.req_valid, err}, 6'b000000);
        chk({tag, "_payload"}, {mem_bus.addr, mem_bus.wen, mem_bus.wmask}, 41'h0);
        chk({tag, "_wdata"}, mem_bus.wdata, 32'h0);
        chk({tag, "_rdata"}, {ifu_bus.rdata, lsu_bus.rdata}, 64'h0);
    endtask

    // One transaction, entered and left at a falling edge with the arbiter idle.
    // rsp_dly < 0 or >= TO means memory stays silent until the timeout.
    task automatic txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                       input bit lw, input logic [31:0] lwd, input logic [7:0] lm,
                       input int rdy_dly, input int rsp_dly, input logic [31:0] mdata);
        bit          win_lsu, tmo;
        logic [31:0] e_addr, e_rd;
        bit          e_wen;
        logic [7:0]  e_mask;
        int          wait_cyc;
        chk("idle_resp", {ifu_bus.resp_valid, lsu_bus.resp_valid, mem_bus.req_valid}, 3'b000);
        ifu_bus.req_valid = iv;
        ifu_bus.addr      = ia;
        lsu_bus.req_valid = lv;
        lsu_bus.addr      = la;
        lsu_bus.wen       = lw;
        lsu_bus.wdata     = lwd;
        lsu_bus.wmask     = lm;
        win_lsu = (iv && lv) ? !last_lsu_m : lv;
        #1;
        chk("grant", {ifu_bus.req_ready, lsu_bus.req_ready}, {~win_lsu, win_lsu});
        last_lsu_m = win_lsu;
        e_addr = win_lsu ? la : ia;
        e_wen  = win_lsu & lw;
        e_mask = win_lsu ? lm : 8'h00;
        @(negedge clk);
        // The winner is free to move its payload once accepted.
        if (win_lsu) begin
            lsu_bus.req_valid = 1'b0;
            lsu_bus.addr      = $urandom;
            lsu_bus.wdata     = $urandom;
        end else begin
            ifu_bus.req_valid = 1'b0;
            ifu_bus.addr      = $urandom;
        end
        for (int k = 0; k <= rdy_dly; k++) begin
            mem_bus.req_ready  = (k == rdy_dly);
            mem_bus.resp_valid = (k != rdy_dly) && ($urandom_range(0, 1) == 1);
            mem_bus.rdata      = $urandom;
            #1;
            chk("mreq_valid", mem_bus.req_valid, 1'b1);
            chk("mreq_payload", {mem_bus.addr, mem_bus.wen, mem_bus.wmask}, {e_addr, e_wen, e_mask});
            if (win_lsu) chk("mreq_wdata", mem_bus.wdata, lwd);
            chk("busy_ready", {ifu_bus.req_ready, lsu_bus.req_ready}, 2'b00);
            @(negedge clk);
        end
        mem_bus.req_ready  = 1'b0;
        mem_bus.resp_valid = 1'b0;
        tmo      = (rsp_dly < 0) || (rsp_dly >= TO);
        wait_cyc = tmo ? TO : rsp_dly + 1;
        for (int c = 0; c < wait_cyc; c++) begin
            mem_bus.resp_valid = !tmo && (c == rsp_dly);
            mem_bus.rdata      = (!tmo && (c == rsp_dly)) ? mdata : $urandom;
            #1;
            chk("mwait_quiet", {mem_bus.req_valid, ifu_bus.resp_valid, lsu_bus.resp_valid}, 3'b000);
            @(negedge clk);
        end
        e_rd = tmo ? POISON : (e_wen ? 32'h0 : mdata);
        if (tmo) err_m = 1'b1;
        if (win_lsu) lsu_rd_m = e_rd;
        else         ifu_rd_m = e_rd;
        // A late answer after a timeout must not disturb anything.
        mem_bus.resp_valid = tmo;
        mem_bus.rdata      = 32'h0badf00d;
        #1;
        chk("resp_valid", {ifu_bus.resp_valid, lsu_bus.resp_valid}, {~win_lsu, win_lsu});
        chk("resp_ready", {ifu_bus.req_ready, lsu_bus.req_ready}, 2'b00);
        chk("ifu_rdata", ifu_bus.rdata, ifu_rd_m);
        chk("lsu_rdata", lsu_bus.rdata, lsu_rd_m);
        chk("err", err, err_m);
        @(negedge clk);
    endtask

    initial begin
        bit          iv, lv;
        int          rsp;
        ifu_bus.req_valid = 1'b0; ifu_bus.addr = '0; ifu_bus.wen = 1'b0;
        ifu_bus.wdata     = '0;   ifu_bus.wmask = '0;
        lsu_bus.req_valid = 1'b0; lsu_bus.addr = '0; lsu_bus.wen = 1'b0;
        lsu_bus.wdata     = '0;   lsu_bus.wmask = '0;
        mem_bus.req_ready = 1'b0; mem_bus.resp_valid = 1'b0; mem_bus.rdata = '0;
        reset_model();

        repeat (2) @(negedge clk);
        #1;
        chk_reset_outs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Both requesting continuously: IFU first, then strict alternation.
        for (int i = 0; i < 4; i++)
            txn(1'b1, 1'b1, 32'h80000100 + 32'(i * 4), 32'h80003000 + 32'(i * 4), 1'b0,
                32'h0, 8'h00, 0, 0, 32'h11110000 + 32'(i));

        // IFU only, minimum latency.
        txn(1'b1, 1'b0, 32'h80000000, 32'h0, 1'b0, 32'h0, 8'h00, 0, 0, 32'h00100073);

        // LSU store: ack carries zero regardless of memory data.
        txn(1'b0, 1'b1, 32'h0, 32'h80001000, 1'b1, 32'h12345678, 8'h0f, 0, 0, 32'hffffffff);

        // Memory holds off acceptance for 10 cycles.
        txn(1'b0, 1'b1, 32'h0, 32'h80001040, 1'b0, 32'h0, 8'h00, 10, 1, 32'hcafef00d);

        // Memory never responds: poison, sticky error, late answer ignored.
        txn(1'b1, 1'b0, 32'h80000040, 32'h0, 1'b0, 32'h0, 8'h00, 0, -1, 32'h0);
        txn(1'b1, 1'b0, 32'h80000044, 32'h0, 1'b0, 32'h0, 8'h00, 0, 2, 32'h01234567);

        // Randomized mix including boundary response delays and timeouts.
        for (int i = 0; i < 24; i++) begin
            iv  = bit'($urandom_range(0, 1));
            lv  = bit'($urandom_range(0, 1));
            if (!iv && !lv) iv = 1'b1;
            rsp = int'($urandom_range(0, 5)) - 1;
            txn(iv, lv, $urandom, $urandom, bit'($urandom_range(0, 1)), $urandom,
                8'($urandom), int'($urandom_range(0, 3)), rsp, $urandom);
        end

        // Reset between clock edges while waiting on memory.
        ifu_bus.req_valid = 1'b1;
        ifu_bus.addr      = 32'h80002000;
        lsu_bus.req_valid = 1'b0;
        #1;
        chk("abort_grant", {ifu_bus.req_ready, lsu_bus.req_ready}, {~last_lsu_m, 1'b0});
        @(negedge clk);
        ifu_bus.req_valid = 1'b0;
        mem_bus.req_ready = 1'b1;
        @(negedge clk);
        mem_bus.req_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outs("abort");
        reset_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mem_bus.resp_valid = 1'b1;
        mem_bus.rdata      = 32'h55555555;
        #1;
        chk("abort_no_resp", {ifu_bus.resp_valid, lsu_bus.resp_valid, mem_bus.req_valid}, 3'b000);
        @(negedge clk);
        mem_bus.resp_valid = 1'b0;
        #1;
        chk("abort_rdata", {ifu_bus.rdata, lsu_bus.rdata, err}, 65'h0);
        @(negedge clk);

        // Normal service afterwards; first conflict after reset goes to IFU again.
        txn(1'b1, 1'b1, 32'h80000200, 32'h80004000, 1'b1, 32'ha5a5a5a5, 8'hf0, 0, 0, 32'h76543210);
        txn(1'b1, 1'b1, 32'h80000204, 32'h80004004, 1'b0, 32'h0, 8'h00, 1, 0, 32'h89abcdef);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
